// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: E/M/W destination-tag scoreboard producing the D-stage stall and mult/div busy tracking
module hazard_scoreboard (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] dest_d,
    input  logic       regwrite_d,
    input  logic [1:0] tnew_d,
    input  logic       md_start_d,
    input  logic       md_div_d,
    input  logic       md_use_d,
    output logic       stall,
    output logic [4:0] wreg_e,
    output logic [4:0] wreg_m,
    output logic [4:0] wreg_w,
    output logic       regwrite_e,
    output logic       regwrite_m,
    output logic       regwrite_w,
    output logic       ready_e,
    output logic       ready_m,
    output logic       md_busy
);
    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    logic [4:0] r_dest_e, r_dest_m, r_dest_w;
    logic       r_rw_e, r_rw_m, r_rw_w;
    logic [1:0] r_tnew_e, r_tnew_m;
    logic [3:0] r_md_cnt;

    logic       w_hz_rs, w_hz_rt, w_md_block, w_stall;
    logic [1:0] w_tnew_e_dec;

    // A source stalls only when an E or M producer cannot deliver before D needs it; W always forwards
    always_comb begin
        w_hz_rs = (rs_d != 5'd0) && (tuse_rs_d != 2'd3) &&
                  ((r_rw_e && r_dest_e == rs_d && r_tnew_e > tuse_rs_d) ||
                   (r_rw_m && r_dest_m == rs_d && r_tnew_m > tuse_rs_d));
        w_hz_rt = (rt_d != 5'd0) && (tuse_rt_d != 2'd3) &&
                  ((r_rw_e && r_dest_e == rt_d && r_tnew_e > tuse_rt_d) ||
                   (r_rw_m && r_dest_m == rt_d && r_tnew_m > tuse_rt_d));
        w_md_block   = (md_use_d || md_start_d) && (r_md_cnt != 4'd0);
        w_stall      = w_hz_rs || w_hz_rt || w_md_block;
        w_tnew_e_dec = (r_tnew_e == 2'd0) ? 2'd0 : r_tnew_e - 2'd1;
    end

    // E stage: take the D instruction, or a bubble while D is held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dest_e <= 5'd0;
            r_rw_e   <= 1'b0;
            r_tnew_e <= 2'd0;
        end else begin
            r_dest_e <= w_stall ? 5'd0 : dest_d;
            r_rw_e   <= w_stall ? 1'b0 : regwrite_d;
            r_tnew_e <= w_stall ? 2'd0 : tnew_d;
        end
    end

    // M and W stages advance every cycle; tnew counts down toward zero on the way
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dest_m <= 5'd0;
            r_rw_m   <= 1'b0;
            r_tnew_m <= 2'd0;
            r_dest_w <= 5'd0;
            r_rw_w   <= 1'b0;
        end else begin
            r_dest_m <= r_dest_e;
            r_rw_m   <= r_rw_e;
            r_tnew_m <= w_tnew_e_dec;
            r_dest_w <= r_dest_m;
            r_rw_w   <= r_rw_m;
        end
    end

    // Mult/div occupancy: a start only takes effect when D actually issues, otherwise it is retried
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt <= 4'd0;
        end else if (md_start_d && !w_stall) begin
            r_md_cnt <= md_div_d ? DIV_CYCLES : MULT_CYCLES;
        end else if (r_md_cnt != 4'd0) begin
            r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

    assign stall      = w_stall;
    assign wreg_e     = r_dest_e;
    assign wreg_m     = r_dest_m;
    assign wreg_w     = r_dest_w;
    assign regwrite_e = r_rw_e;
    assign regwrite_m = r_rw_m;
    assign regwrite_w = r_rw_w;
    assign ready_e    = r_rw_e && (r_tnew_e == 2'd0);
    assign ready_m    = r_rw_m && (r_tnew_m == 2'd0);
    assign md_busy    = (r_md_cnt != 4'd0);
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low; 0 clears all state immediately.
REQ-003 SHALL have ports rs_d, rt_d  input  5 each  D-stage source register numbers.
REQ-004 SHALL have ports tuse_rs_d, tuse_rt_d  input  2 each  cycles until the D instruction needs the operand; 3 = operand unused.
REQ-005 SHALL have ports dest_d (input, 5), regwrite_d (input, 1), tnew_d (input, 2)  D instruction's destination, write enable, and cycles after entering E until its result exists (0..2).
REQ-006 SHALL have ports md_start_d, md_div_d, md_use_d  input  1 each  D instruction starts mult/div; 1 = div; D instruction reads or writes HI/LO.
REQ-007 SHALL have port stall  output  1  freeze PC/F/D; a bubble enters E.
REQ-008 SHALL have ports wreg_e, wreg_m, wreg_w  output  5 each  destination tag per stage.
REQ-009 SHALL have ports regwrite_e, regwrite_m, regwrite_w  output  1 each  tag valid per stage.
REQ-010 SHALL have ports ready_e, ready_m  output  1 each  the stage's result is forwardable this cycle.
REQ-011 SHALL have port md_busy  output  1  mult/div unit occupied.

Function
REQ-012 SHALL hold per-stage tag registers for E, M, and W: dest (5b), regwrite (1b), tnew (2b).
REQ-013 SHALL, each cycle, load E from the D inputs when stall=0 and load E with a bubble (dest=0, regwrite=0, tnew=0) when stall=1.
REQ-014 SHALL advance M<=E and W<=M every cycle regardless of stall, with tnew decremented on each advance and saturating at 0.
REQ-015 SHALL drive ready_e=regwrite_e&&tnew_e==0 and ready_m=regwrite_m&&tnew_m==0; a W-stage result is always ready.
REQ-016 SHALL, for source s in {rs,rt}, raise hazard_s when s!=0 and tuse_s!=3 and either (regwrite_e && wreg_e==s && tnew_e>tuse_s) or (regwrite_m && wreg_m==s && tnew_m>tuse_s).
REQ-017 SHALL never let a W-stage match cause a stall.
REQ-018 SHALL contain a 4-bit mult/div counter that loads 5 (mult) or 10 (div) when md_start_d=1 and stall=0, and otherwise decrements by 1 per cycle down to 0.
REQ-019 SHALL drive md_busy=(counter!=0).
REQ-020 SHALL drive stall = hazard_rs | hazard_rt | ((md_use_d|md_start_d) & md_busy), purely combinationally from current state and D inputs.
REQ-021 SHALL not load the counter when md_start_d=1 and stall=1 in the same cycle; the start is retried on a later cycle.
REQ-022 SHALL evaluate rs and rt independently; rs==rt matching the same tag SHALL produce one stall, not an error.
REQ-023 SHALL give E priority over M when both hold the same dest; a stall still results if either term of REQ-016 is true.
REQ-024 SHALL not stall on a register-0 destination; regwrite with dest=0 SHALL still propagate as a tag.

Reset
REQ-025 SHALL, while reset=0, force all tags to 0, regwrite_* to 0, the counter to 0, stall to 0 (absent D hazards against cleared tags), ready_* to 0, and md_busy to 0.
REQ-026 SHALL, when reset asserts mid-operation (counter nonzero or tags live), clear all of that state asynchronously without waiting for clk.
REQ-027 SHALL resume normal operation on the first rising clk edge after reset returns to 1.

Verification
REQ-028 SHALL cover load-use: E holds lw dest=8, tnew_e=2; D has rs_d=8, tuse_rs=0 -> stall=1 for 2 cycles, then 0 with ready_m=0 then W.
REQ-029 SHALL cover ALU forwarding: E holds dest=9, tnew=1; D has rt_d=9, tuse_rt=1 -> stall=0.
REQ-030 SHALL cover register zero: E holds dest=0, regwrite=1, tnew=2; D has rs_d=0, tuse=0 -> stall=0.
REQ-031 SHALL cover div: md_start_d=1, md_div_d=1 accepted -> md_busy=1 for 10 cycles; mfhi in D (md_use_d=1) stalls all 10 and issues on cycle 11.
REQ-032 SHALL cover mult retry: mult issued while rs hazard is active -> counter stays 0 until stall drops, then loads 5.
REQ-033 SHALL cover async reset: reset=0 pulsed mid-clock while the counter is 7 and the tags are valid -> md_busy, regwrite_*, and stall go to 0 before the next edge.
